// File: rtl/median_filter_3x3_if.sv
// Pixel-stream and frame-control signals of the 3x3 median/min/max filter.
// The filter itself connects through the slave modport; the source/sink side uses master.
interface median_filter_3x3_if #(
    parameter int PIX_W = 24
);
    logic             start_i;
    logic [1:0]       mode_i;
    logic             valid_i;
    logic [PIX_W-1:0] pixel_i;
    logic             valid_o;
    logic [PIX_W-1:0] pixel_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, mode_i, valid_i, pixel_i,
        input  valid_o, pixel_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mode_i, valid_i, pixel_i,
        output valid_o, pixel_o, busy_o, done_o
    );
endinterface

// File: rtl/median_filter_3x3.sv
// Streaming 3x3 window filter (median / min / max / centre bypass) over raster-order frames.
// Two line buffers feed a 3x3 window; a 3-stage row-sort selection network follows.
//
// state   | meaning
// S_IDLE  | waiting for start_i; mode and counters latched/cleared on start
// S_RUN   | accepting pixels until the last pixel of the frame
// S_DRAIN | no more input; waiting for the selection pipeline to empty
// S_DONE  | one-cycle end-of-frame pulse on done_o
module median_filter_3x3 #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int CHANNELS     = 3,
    parameter int CHAN_W       = 8
) (
    input logic              clk,
    input logic              rst_n,
    median_filter_3x3_if.slave bus
);
    localparam int PIX_W = CHANNELS * CHAN_W;
    localparam int X_W   = $clog2(IMAGE_LEN);
    localparam int Y_W   = $clog2(IMAGE_HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_LEN - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic [CHAN_W-1:0] chan_t;

    function automatic chan_t min2(input chan_t a, input chan_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic chan_t max2(input chan_t a, input chan_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic chan_t min3(input chan_t a, input chan_t b, input chan_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic chan_t max3(input chan_t a, input chan_t b, input chan_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic chan_t med3(input chan_t a, input chan_t b, input chan_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t state_q, state_d;
    logic   busy, done;

    logic             accept, start_acc, last_pix, interior, pipe_busy;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [1:0]       mode_q;

    logic [PIX_W-1:0] lb_near [IMAGE_LEN];
    logic [PIX_W-1:0] lb_far  [IMAGE_LEN];
    logic [PIX_W-1:0] near_rd, far_rd;

    // win_q[row][col]: row 0 = line y-2, row 2 = current line; col 2 = newest column
    logic [2:0][2:0][PIX_W-1:0] win_q;
    logic                       win_vld;

    logic [CHANNELS-1:0][2:0][CHAN_W-1:0] s1_lo_d, s1_md_d, s1_hi_d;
    logic [CHANNELS-1:0][2:0][CHAN_W-1:0] s1_lo_q, s1_md_q, s1_hi_q;
    logic [PIX_W-1:0]                     s1_ctr_q;
    logic                                 s1_vld;

    logic [CHANNELS-1:0][CHAN_W-1:0] s2_lmax_d, s2_mmed_d, s2_hmin_d, s2_min_d, s2_max_d;
    logic [CHANNELS-1:0][CHAN_W-1:0] s2_lmax_q, s2_mmed_q, s2_hmin_q, s2_min_q, s2_max_q;
    logic [PIX_W-1:0]                s2_ctr_q;
    logic                            s2_vld;

    logic [PIX_W-1:0] s3_res_d, s3_res_q;
    logic             s3_vld;

    logic [PIX_W-1:0] out_pix_q;
    logic             out_vld_q;

    assign accept    = bus.valid_i && (state_q == S_RUN);
    assign start_acc = bus.start_i && (state_q == S_IDLE);
    assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign interior  = (x_q >= X_W'(2)) && (y_q >= Y_W'(2));
    assign pipe_busy = win_vld || s1_vld || s2_vld || s3_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && last_pix) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // output register may still hold the last pixel; done follows it by one cycle
                if (!pipe_busy) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= 2'b00;
        end else if (start_acc) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= bus.mode_i;
        end else if (accept) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

    assign near_rd = lb_near[x_q];
    assign far_rd  = lb_far[x_q];

    // line storage carries no reset: rows above y=2 are always rewritten before use
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_near[x_q] <= bus.pixel_i;
            lb_far[x_q]  <= near_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            win_vld <= 1'b0;
        end else begin
            win_vld <= accept && interior;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= far_rd;
                win_q[1][2] <= near_rd;
                win_q[2][2] <= bus.pixel_i;
            end
        end
    end

    always_comb begin
        s1_lo_d = '0;
        s1_md_d = '0;
        s1_hi_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int r = 0; r < 3; r++) begin
                s1_lo_d[ch][r] = min3(win_q[r][0][ch*CHAN_W +: CHAN_W],
                                      win_q[r][1][ch*CHAN_W +: CHAN_W],
                                      win_q[r][2][ch*CHAN_W +: CHAN_W]);
                s1_md_d[ch][r] = med3(win_q[r][0][ch*CHAN_W +: CHAN_W],
                                      win_q[r][1][ch*CHAN_W +: CHAN_W],
                                      win_q[r][2][ch*CHAN_W +: CHAN_W]);
                s1_hi_d[ch][r] = max3(win_q[r][0][ch*CHAN_W +: CHAN_W],
                                      win_q[r][1][ch*CHAN_W +: CHAN_W],
                                      win_q[r][2][ch*CHAN_W +: CHAN_W]);
            end
        end
    end

    // median of 9 = med3(max of row mins, med of row medians, min of row maxes)
    always_comb begin
        s2_lmax_d = '0;
        s2_mmed_d = '0;
        s2_hmin_d = '0;
        s2_min_d  = '0;
        s2_max_d  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            s2_lmax_d[ch] = max3(s1_lo_q[ch][0], s1_lo_q[ch][1], s1_lo_q[ch][2]);
            s2_mmed_d[ch] = med3(s1_md_q[ch][0], s1_md_q[ch][1], s1_md_q[ch][2]);
            s2_hmin_d[ch] = min3(s1_hi_q[ch][0], s1_hi_q[ch][1], s1_hi_q[ch][2]);
            s2_min_d[ch]  = min3(s1_lo_q[ch][0], s1_lo_q[ch][1], s1_lo_q[ch][2]);
            s2_max_d[ch]  = max3(s1_hi_q[ch][0], s1_hi_q[ch][1], s1_hi_q[ch][2]);
        end
    end

    always_comb begin
        s3_res_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (mode_q)
                2'b00:   s3_res_d[ch*CHAN_W +: CHAN_W] = med3(s2_lmax_q[ch], s2_mmed_q[ch], s2_hmin_q[ch]);
                2'b01:   s3_res_d[ch*CHAN_W +: CHAN_W] = s2_min_q[ch];
                2'b10:   s3_res_d[ch*CHAN_W +: CHAN_W] = s2_max_q[ch];
                default: s3_res_d[ch*CHAN_W +: CHAN_W] = s2_ctr_q[ch*CHAN_W +: CHAN_W];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lo_q   <= '0;
            s1_md_q   <= '0;
            s1_hi_q   <= '0;
            s1_ctr_q  <= '0;
            s1_vld    <= 1'b0;
            s2_lmax_q <= '0;
            s2_mmed_q <= '0;
            s2_hmin_q <= '0;
            s2_min_q  <= '0;
            s2_max_q  <= '0;
            s2_ctr_q  <= '0;
            s2_vld    <= 1'b0;
            s3_res_q  <= '0;
            s3_vld    <= 1'b0;
            out_pix_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            s1_lo_q   <= s1_lo_d;
            s1_md_q   <= s1_md_d;
            s1_hi_q   <= s1_hi_d;
            s1_ctr_q  <= win_q[1][1];
            s1_vld    <= win_vld;
            s2_lmax_q <= s2_lmax_d;
            s2_mmed_q <= s2_mmed_d;
            s2_hmin_q <= s2_hmin_d;
            s2_min_q  <= s2_min_d;
            s2_max_q  <= s2_max_d;
            s2_ctr_q  <= s1_ctr_q;
            s2_vld    <= s1_vld;
            s3_res_q  <= s3_res_d;
            s3_vld    <= s2_vld;
            out_pix_q <= s3_vld ? s3_res_q : '0;
            out_vld_q <= s3_vld;
        end
    end

    assign bus.valid_o = out_vld_q;
    assign bus.pixel_o = out_pix_q;
    assign bus.busy_o  = busy;
    assign bus.done_o  = done;
endmodule

// File: tb/tb_median_filter_3x3.sv
// Scoreboard bench: an 8x6 three-channel 8-bit filter and a 3x3 single-channel 12-bit filter.
// Drivers push expected pixels with their acceptance cycle; monitors pop on valid_o.
module tb_median_filter_3x3;
    localparam int A_LEN = 8;
    localparam int A_HGT = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_filter_3x3_if #(.PIX_W(24)) bus_a ();
    median_filter_3x3_if #(.PIX_W(12)) bus_b ();

    median_filter_3x3 #(.IMAGE_LEN(A_LEN), .IMAGE_HEIGHT(A_HGT), .CHANNELS(3), .CHAN_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    median_filter_3x3 #(.IMAGE_LEN(3), .IMAGE_HEIGHT(3), .CHANNELS(1), .CHAN_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        logic [23:0] pix;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_a = 0;
    int          done_b = 0;
    int          last_vo_a = -10;
    int          last_vo_b = -10;
    logic [23:0] fa [A_HGT][A_LEN];
    logic [11:0] fb [9];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Golden model: full sort of the 9 neighbours per channel
    function automatic logic [23:0] model_a(input int x, input int y, input logic [1:0] mode);
        logic [7:0]  v [9];
        logic [7:0]  t;
        logic [23:0] r;
        int          k;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            k = 0;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++) begin
                    v[k] = fa[y-2+dy][x-2+dx][ch*8 +: 8];
                    k++;
                end
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8 - i; j++)
                    if (v[j] > v[j+1]) begin
                        t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                    end
            case (mode)
                2'b00:   r[ch*8 +: 8] = v[4];
                2'b01:   r[ch*8 +: 8] = v[0];
                2'b10:   r[ch*8 +: 8] = v[8];
                default: r[ch*8 +: 8] = fa[y-1][x-1][ch*8 +: 8];
            endcase
        end
        return r;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_a.valid_o) begin
                    last_vo_a = cyc;
                    if (q_a.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL a_unexpected_out: got %0h, want no output (cycle %0d)", bus_a.pixel_o, cyc);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_pixel", 32'(bus_a.pixel_o), 32'(e.pix));
                        chk("a_latency", cyc, e.cyc + 4);
                    end
                end else begin
                    chk("a_pixel_zero", 32'(bus_a.pixel_o), 0);
                end
                if (bus_a.done_o) begin
                    done_a++;
                    chk("a_done_timing", cyc, last_vo_a + 1);
                end
                if (bus_b.valid_o) begin
                    last_vo_b = cyc;
                    if (q_b.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL b_unexpected_out: got %0h, want no output (cycle %0d)", bus_b.pixel_o, cyc);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_pixel", 32'(bus_b.pixel_o), 32'(e.pix));
                        chk("b_latency", cyc, e.cyc + 4);
                    end
                end else begin
                    chk("b_pixel_zero", 32'(bus_b.pixel_o), 0);
                end
                if (bus_b.done_o) begin
                    done_b++;
                    chk("b_done_timing", cyc, last_vo_b + 1);
                end
            end
        end
    end

    task automatic wait_done(input bit is_a);
        int d0;
        d0 = is_a ? done_a : done_b;
        for (int i = 0; i < 40; i++) begin
            if ((is_a ? done_a : done_b) != d0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        if (is_a) begin
            chk("a_done_count", done_a - d0, 1);
            chk("a_queue_drained", q_a.size(), 0);
            chk("a_busy_after", 32'(bus_a.busy_o), 0);
        end else begin
            chk("b_done_count", done_b - d0, 1);
            chk("b_queue_drained", q_b.size(), 0);
            chk("b_busy_after", 32'(bus_b.busy_o), 0);
        end
    endtask

    // kind: 0 ramp x+8y, 1 random, 2 random with heavy duplicates; rst_x >= 0 aborts at (rst_x, 2)
    task automatic run_frame_a(input logic [1:0] mode, input int kind, input int gap_pct,
                               input bit disturb, input int rst_x);
        exp_t e;
        for (int y = 0; y < A_HGT; y++)
            for (int x = 0; x < A_LEN; x++)
                fa[y][x] = (kind == 0) ? {3{8'(x + 8*y)}} :
                           (kind == 1) ? 24'($urandom) : 24'($urandom & 32'h0003_0303);
        if (disturb) begin
            for (int i = 0; i < 3; i++) begin
                bus_a.valid_i = 1'b1;
                bus_a.pixel_i = 24'($urandom);
                @(negedge clk);
            end
            bus_a.valid_i = 1'b0;
            chk("a_idle_busy", 32'(bus_a.busy_o), 0);
        end
        bus_a.start_i = 1'b1;
        bus_a.mode_i  = mode;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        bus_a.mode_i  = ~mode;
        chk("a_run_busy", 32'(bus_a.busy_o), 1);
        for (int y = 0; y < A_HGT; y++) begin
            for (int x = 0; x < A_LEN; x++) begin
                while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    bus_a.valid_i = 1'b0;
                    @(negedge clk);
                end
                if (y == 2 && x == rst_x) begin
                    chk("a_pre_reset_valid", 32'(bus_a.valid_o), 1);
                    rst_n = 1'b0;
                    #1;
                    chk("a_reset_valid", 32'(bus_a.valid_o), 0);
                    chk("a_reset_busy", 32'(bus_a.busy_o), 0);
                    chk("a_reset_pixel", 32'(bus_a.pixel_o), 0);
                    q_a.delete();
                    bus_a.valid_i = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                bus_a.valid_i = 1'b1;
                bus_a.pixel_i = fa[y][x];
                if (disturb && y == 1 && x == 3) bus_a.start_i = 1'b1;
                if (x >= 2 && y >= 2) begin
                    e.pix = (kind == 0) ? {3{8'(x - 1 + 8*(y - 1))}} : model_a(x, y, mode);
                    e.cyc = cyc + 1;
                    q_a.push_back(e);
                end
                @(negedge clk);
                bus_a.start_i = 1'b0;
            end
        end
        bus_a.valid_i = 1'b0;
        if (disturb) begin
            bus_a.valid_i = 1'b1;
            bus_a.start_i = 1'b1;
            bus_a.pixel_i = '1;
            repeat (3) @(negedge clk);
            bus_a.valid_i = 1'b0;
            bus_a.start_i = 1'b0;
        end
        wait_done(1'b1);
    endtask

    task automatic run_frame_b(input logic [1:0] mode, input logic [11:0] expv);
        exp_t e;
        bus_b.start_i = 1'b1;
        bus_b.mode_i  = mode;
        @(negedge clk);
        bus_b.start_i = 1'b0;
        bus_b.mode_i  = ~mode;
        for (int i = 0; i < 9; i++) begin
            bus_b.valid_i = 1'b1;
            bus_b.pixel_i = fb[i];
            if (i == 8) begin
                e.pix = {12'd0, expv};
                e.cyc = cyc + 1;
                q_b.push_back(e);
            end
            @(negedge clk);
        end
        bus_b.valid_i = 1'b0;
        wait_done(1'b0);
    endtask

    initial begin
        bus_a.start_i = 1'b0; bus_a.mode_i = 2'b00; bus_a.valid_i = 1'b0; bus_a.pixel_i = '0;
        bus_b.start_i = 1'b0; bus_b.mode_i = 2'b00; bus_b.valid_i = 1'b0; bus_b.pixel_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_rst_valid", 32'(bus_a.valid_o), 0);
        chk("a_rst_pixel", 32'(bus_a.pixel_o), 0);
        chk("a_rst_busy",  32'(bus_a.busy_o), 0);
        chk("a_rst_done",  32'(bus_a.done_o), 0);
        chk("b_rst_valid", 32'(bus_b.valid_o), 0);
        chk("b_rst_busy",  32'(bus_b.busy_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame_a(2'b00, 0, 0,  1'b0, -1);
        run_frame_a(2'b00, 1, 50, 1'b1, -1);
        run_frame_a(2'b01, 1, 50, 1'b0, -1);
        run_frame_a(2'b10, 2, 0,  1'b0, -1);
        run_frame_a(2'b11, 1, 30, 1'b0, -1);
        run_frame_a(2'b00, 2, 40, 1'b0, -1);
        run_frame_a(2'b00, 1, 0,  1'b0, 7);
        run_frame_a(2'b00, 1, 50, 1'b1, -1);

        fb = '{12'd9, 12'd1, 12'd8, 12'd2, 12'd7, 12'd3, 12'd6, 12'd4, 12'd5};
        run_frame_b(2'b00, 12'd5);
        run_frame_b(2'b01, 12'd1);
        run_frame_b(2'b10, 12'd9);
        run_frame_b(2'b11, 12'd7);

        fb = '{12'd4095, 12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd4095, 12'd1};
        run_frame_b(2'b00, 12'd1);
        run_frame_b(2'b01, 12'd0);
        run_frame_b(2'b10, 12'd4095);
        run_frame_b(2'b11, 12'd4095);

        fb = '{12'd4095, 12'd0, 12'd4095, 12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd4095};
        run_frame_b(2'b00, 12'd4095);

        fb = '{12'd4094, 12'd4095, 12'd4095, 12'd4093, 12'd4095, 12'd0, 12'd0, 12'd1, 12'd2};
        run_frame_b(2'b00, 12'd4093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1);
    end
endmodule

// File: doc/median_filter_3x3.md
MEDIAN_FILTER_3X3 -- requirements
Module: median_filter_3x3

Interface
REQ-001 SHALL have parameter IMAGE_LEN, default 1080, pixels per line (>=3).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 720, lines per frame (>=3).
REQ-003 SHALL have parameter CHANNELS, default 3, colour channels per pixel.
REQ-004 SHALL have parameter CHAN_W, default 8, bits per channel; PIX_W = CHANNELS*CHAN_W.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_i, input, 1, frame start pulse, sampled only in IDLE.
REQ-008 SHALL have port mode_i, input, 2, op select: 00 median, 01 min, 10 max, 11 bypass (centre pixel), latched on accepted start_i.
REQ-009 SHALL have port valid_i, input, 1, input pixel valid, raster order, no backpressure.
REQ-010 SHALL have port pixel_i, input, PIX_W, channel 0 in LSBs.
REQ-011 SHALL have port valid_o, output, 1, output pixel valid.
REQ-012 SHALL have port pixel_o, output, PIX_W, filtered pixel, channel 0 in LSBs.
REQ-013 SHALL have port busy_o, output, 1, high in RUN and DRAIN.
REQ-014 SHALL have port done_o, output, 1, one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start_i; RUN -> DRAIN when pixel (IMAGE_LEN-1, IMAGE_HEIGHT-1) accepted; DRAIN -> DONE after pipeline empty; DONE -> IDLE next cycle.
REQ-016 SHALL accept pixels (valid_i=1) only in RUN; valid_i in IDLE/DRAIN/DONE ignored, counters and buffers unchanged.
REQ-017 SHALL ignore start_i outside IDLE; mode_i changes outside IDLE have no effect.
REQ-018 SHALL clear x/y counters on accepted start_i; x wraps at IMAGE_LEN-1 incrementing y.
REQ-019 SHALL hold two line buffers of IMAGE_LEN entries each and a 3x3 window shifted only on accepted pixels.
REQ-020 SHALL produce output only for interior centres: one output per accepted pixel with x>=2 and y>=2, centre (x-1, y-1); (IMAGE_LEN-2)*(IMAGE_HEIGHT-2) outputs per frame.
REQ-021 SHALL assert valid_o exactly 4 cycles after the accepted pixel completing the window, regardless of gaps in valid_i.
REQ-022 SHALL compute each channel independently, unsigned, CHAN_W bits; median = 5th smallest of 9 values, exact, no rounding.
REQ-023 SHALL compute min/max modes as the smallest/largest of 9 values per channel; bypass outputs window centre with identical latency.
REQ-024 SHALL pipeline the selection network in 3 register stages; one new window per cycle sustained.
REQ-025 SHALL drive pixel_o to 0 when valid_o=0.
REQ-026 SHALL assert done_o for one cycle in DONE, exactly one cycle after last valid_o of frame.
REQ-027 SHALL not use line-buffer contents from a previous frame: rows y<2 of a new frame never produce output.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force IDLE, valid_o=0, pixel_o=0, busy_o=0, done_o=0, counters 0, latched mode 00.
REQ-029 SHALL abandon any frame in progress on reset; line-buffer contents need not be cleared.
REQ-030 SHALL resume only on start_i after rst_n deasserts.

Verification
REQ-031 SHALL cover: IMAGE_LEN=5, HEIGHT=4, mode 00, pixel value = x+5y per channel -> 6 outputs, each = centre value, first valid_o 4 cycles after pixel (2,2).
REQ-032 SHALL cover: 3x3 frame, ch0 values 9,1,8,2,7,3,6,4,5, mode 00/01/10/11 -> single output 5/1/9/7.
REQ-033 SHALL cover: random valid_i gaps (50%) on 8x6 frame vs golden model -> identical output sequence, 24 outputs, one done_o pulse.
REQ-034 SHALL cover: valid_i and start_i asserted in IDLE/DRAIN -> no outputs, no state change; second start_i mid-RUN ignored.
REQ-035 SHALL cover: rst_n low mid-frame (y=2) -> valid_o, busy_o 0 same cycle; new frame after start_i matches golden model.
REQ-036 SHALL cover: CHANNELS=1, CHAN_W=12, values 4095 and 0 mixed -> exact median, no overflow.
